// File: rtl/cnn_pkg.sv
// Shared types, default widths and the saturating narrow helper for the CNN
// systolic array (PE and output collector).
package cnn_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} pe_state_t;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;

  // Clamp a sign-extended value into the signed range of out_w bits.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                    input int out_w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pe_requant.sv
// Combinational requantiser: arithmetic right shift then narrow to OUT_W.
// PE_SATURATE_EN selects clamping; otherwise two's-complement truncation.
module pe_requant
  import cnn_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

`ifdef PE_SATURATE_EN
  logic signed [IN_W-1:0] sh;
  logic signed [63:0]     ext;

  always_comb begin
    sh   = din >>> SHIFT;
    ext  = {{(64-IN_W){sh[IN_W-1]}}, sh};
    dout = OUT_W'(sat_narrow(ext, OUT_W));
  end
`else
  always_comb dout = OUT_W'(din >>> SHIFT);
`endif

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary MAC PE: forwards operands east/south, accumulates a
// variable-length dot product and holds the requantised result until drained.
// Requantisation mode is set by PE_SATURATE_EN (see pe_requant).
module systolic_mac_pe
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ACC_W  = cnn_pkg::ACC_W,
  parameter int OUT_W  = cnn_pkg::OUT_W,
  parameter int K_MAX  = 256,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_last,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_a,
  output logic signed [DATA_W-1:0] out_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [OUT_W-1:0]  res_data,
  output logic                     err
);

  localparam int CW = $clog2(K_MAX + 1);

  pe_state_t               state, state_n;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic [CW-1:0]           term_cnt, cnt_n, cnt_inc;
  logic                    err_set;
  logic                    acc_in;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign in_ready  = (state != HOLD);
  assign res_valid = (state == HOLD);
  assign acc_in    = in_valid & in_ready;

  assign prod     = in_a * in_b;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  // First term of a dot product restarts the count at 1.
  assign cnt_inc  = (state == IDLE) ? CW'(1) : term_cnt + 1'b1;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = term_cnt;
    err_set = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (acc_in) begin
          acc_n = ((state == IDLE) ? '0 : acc) + prod_ext;
          cnt_n = cnt_inc;
          if (in_last) begin
            state_n = HOLD;
          end else if (cnt_inc == CW'(K_MAX)) begin
            state_n = HOLD;
            err_set = 1'b1;
          end else begin
            state_n = ACCUM;
          end
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_n = IDLE;
          acc_n   = '0;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      term_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      term_cnt <= cnt_n;
      if (err_set) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else begin
      out_valid <= acc_in;
      if (acc_in) begin
        out_a <= in_a;
        out_b <= in_b;
      end
    end
  end

  pe_requant #(.IN_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_requant (
    .din  (acc),
    .dout (res_data)
  );

endmodule
